// File: rtl/lpc_pkg.sv
// rtl/lpc_pkg.sv - LPC target shared types, bus constants and window-match helper
package lpc_pkg;

   typedef enum logic [3:0] {
      IDLE, START, CYCTYPE, ADDR, WDATA, HTAR, SYNC, RDATA, TTAR
   } lpc_state_e;

   localparam logic [3:0]  LPC_START   = 4'h0;
   localparam logic [3:0]  LPC_SYNC_OK = 4'h0;
   localparam logic [3:0]  LPC_TAR     = 4'hF;
   localparam logic [2:0]  CYC_IO_RD   = 3'b000;
   localparam logic [2:0]  CYC_IO_WR   = 3'b001;
   localparam logic [15:0] POST_PORT   = 16'h0080;

   function automatic logic in_window(input logic [15:0] a, input logic [15:0] base,
                                      input int win_bits);
      return (a >> win_bits) == (base >> win_bits);
   endfunction

endpackage

// File: rtl/lpc_lad_drv.sv
// rtl/lpc_lad_drv.sv - registered LAD driver: SYNC, read-data nibbles and turnaround
module lpc_lad_drv
   import lpc_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  lpc_state_e state_i,
   input  logic       nib_i,
   input  logic       drive_i,
   input  logic [7:0] rd_data_i,
   output logic [3:0] lad_o,
   output logic       oe_o
);

   logic [3:0] lad_q, lad_d;
   logic       oe_q, oe_d;
   logic [7:0] shadow_q, shadow_d;

   // state_i is the phase being entered, so the pins change on the same edge
   always_comb begin
      lad_d    = LPC_TAR;
      oe_d     = 1'b0;
      shadow_d = shadow_q;
      case (state_i)
         SYNC: begin
            lad_d    = LPC_SYNC_OK;
            oe_d     = drive_i;
            shadow_d = rd_data_i;
         end
         RDATA: begin
            lad_d = nib_i ? shadow_q[7:4] : shadow_q[3:0];
            oe_d  = drive_i;
         end
         TTAR:    oe_d = drive_i;
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         lad_q    <= LPC_TAR;
         oe_q     <= 1'b0;
         shadow_q <= 8'h00;
      end else begin
         lad_q    <= lad_d;
         oe_q     <= oe_d;
         shadow_q <= shadow_d;
      end
   end

   assign lad_o = lad_q;
   assign oe_o  = oe_q;

endmodule

// File: rtl/lpc_io_decoder.sv
// rtl/lpc_io_decoder.sv - LPC I/O cycle decoder for a 2**WIN_BITS byte window
// Optional POST port 0x0080 write snoop enabled by LPC_POST80_EN.
module lpc_io_decoder
   import lpc_pkg::*;
#(
   parameter logic [15:0] BASE_ADDR = 16'h0800,
   parameter int          WIN_BITS  = 5
) (
   input  logic       LpcClock,
   input  logic       PciReset,
   input  logic       LFRAME_n,
   input  logic [3:0] LAD_in,
   output logic [3:0] LAD_out,
   output logic       LAD_oe,
   input  logic [7:0] RdData,
   output logic [7:0] Addr,
   output logic       Wr,
   output logic [7:0] DataWr,
   output logic [7:0] PostCode
);

   lpc_state_e  state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic        is_wr_q, is_wr_d;
   logic        drive_q, drive_d;
   logic [11:0] ioaddr_q, ioaddr_d;
   logic [7:0]  wdata_q, wdata_d;
   logic [7:0]  addr_q, addr_d;
   logic        wr_q, wr_d;
   logic [7:0]  datawr_q, datawr_d;
   logic [15:0] full_addr;
   logic        addr_hit;

   assign full_addr = {ioaddr_q, LAD_in};
   assign addr_hit  = in_window(full_addr, BASE_ADDR, WIN_BITS);

`ifdef LPC_POST80_EN
   logic       post_q, post_d;
   logic [7:0] postcode_q, postcode_d;
   logic       post_hit;
   assign post_hit = is_wr_q && (full_addr == POST_PORT);
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      is_wr_d  = is_wr_q;
      drive_d  = drive_q;
      ioaddr_d = ioaddr_q;
      wdata_d  = wdata_q;
      addr_d   = addr_q;
      wr_d     = 1'b0;
      datawr_d = datawr_q;
`ifdef LPC_POST80_EN
      post_d     = post_q;
      postcode_d = postcode_q;
`endif
      // a START nibble under LFRAME# overrides whatever cycle was in flight
      if (!LFRAME_n) begin
         cnt_d   = 2'd0;
         drive_d = 1'b0;
`ifdef LPC_POST80_EN
         post_d  = 1'b0;
`endif
         state_d = (LAD_in == LPC_START) ? START : IDLE;
      end else begin
         case (state_q)
            IDLE: ;
            START: begin
               if (LAD_in[3:1] == CYC_IO_RD || LAD_in[3:1] == CYC_IO_WR) begin
                  state_d = CYCTYPE;
                  is_wr_d = (LAD_in[3:1] == CYC_IO_WR);
               end else begin
                  state_d = IDLE;
               end
            end
            CYCTYPE: begin
               state_d  = ADDR;
               cnt_d    = 2'd0;
               ioaddr_d = full_addr[11:0];
            end
            ADDR: begin
               if (cnt_q != 2'd3) begin
                  ioaddr_d = full_addr[11:0];
                  cnt_d    = cnt_q + 2'd1;
               end
               if (cnt_q == 2'd2) begin
                  drive_d = addr_hit;
                  if (addr_hit)
                     addr_d = {{(8-WIN_BITS){1'b0}}, full_addr[WIN_BITS-1:0]};
`ifdef LPC_POST80_EN
                  post_d = post_hit;
                  if (!addr_hit && !post_hit) state_d = IDLE;
`else
                  if (!addr_hit) state_d = IDLE;
`endif
               end else if (cnt_q == 2'd3) begin
                  cnt_d   = 2'd0;
                  state_d = is_wr_q ? WDATA : HTAR;
                  if (is_wr_q) wdata_d[3:0] = LAD_in;
               end
            end
            WDATA: begin
               if (cnt_q == 2'd0) begin
                  wdata_d[7:4] = LAD_in;
                  cnt_d        = 2'd1;
               end else begin
                  state_d = HTAR;
                  cnt_d   = 2'd0;
               end
            end
            HTAR: begin
               if (cnt_q == 2'd0) begin
                  cnt_d = 2'd1;
               end else begin
                  state_d = SYNC;
                  wr_d    = is_wr_q && drive_q;
                  if (is_wr_q && drive_q) datawr_d = wdata_q;
`ifdef LPC_POST80_EN
                  if (post_q) postcode_d = wdata_q;
`endif
               end
            end
            SYNC: begin
               cnt_d   = 2'd0;
               state_d = is_wr_q ? TTAR : RDATA;
            end
            RDATA: begin
               if (cnt_q == 2'd0) cnt_d = 2'd1;
               else state_d = TTAR;
            end
            TTAR:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge LpcClock or negedge PciReset) begin
      if (!PciReset) begin
         state_q  <= IDLE;
         cnt_q    <= 2'd0;
         is_wr_q  <= 1'b0;
         drive_q  <= 1'b0;
         ioaddr_q <= 12'h000;
         wdata_q  <= 8'h00;
         addr_q   <= 8'h00;
         wr_q     <= 1'b0;
         datawr_q <= 8'h00;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         is_wr_q  <= is_wr_d;
         drive_q  <= drive_d;
         ioaddr_q <= ioaddr_d;
         wdata_q  <= wdata_d;
         addr_q   <= addr_d;
         wr_q     <= wr_d;
         datawr_q <= datawr_d;
      end
   end

`ifdef LPC_POST80_EN
   always_ff @(posedge LpcClock or negedge PciReset) begin
      if (!PciReset) begin
         post_q     <= 1'b0;
         postcode_q <= 8'h00;
      end else begin
         post_q     <= post_d;
         postcode_q <= postcode_d;
      end
   end
   assign PostCode = postcode_q;
`else
   assign PostCode = 8'h00;
`endif

   lpc_lad_drv u_lad_drv (
      .clk_i     (LpcClock),
      .rst_n_i   (PciReset),
      .state_i   (state_d),
      .nib_i     (cnt_d[0]),
      .drive_i   (drive_d),
      .rd_data_i (RdData),
      .lad_o     (LAD_out),
      .oe_o      (LAD_oe)
   );

   assign Addr   = addr_q;
   assign Wr     = wr_q;
   assign DataWr = datawr_q;

endmodule
